// File: rtl/park_pkg.sv
// Shared types and helpers for the parking-lot occupancy manager.
package park_pkg;

   typedef enum logic {
      S_RUN,
      S_RECOUNT
   } park_state_e;

   localparam int unsigned STAT_W    = 16;
   localparam int unsigned POP_MAX_W = 256;

   // Operand is zero-padded to the largest supported lot size.
   function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < POP_MAX_W; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/park_free_finder.sv
// Combinational lowest-index free-bay search over the occupancy vector.
module park_free_finder #(
   parameter int unsigned NUM_SLOTS = 8,
   parameter int unsigned TOKEN_W   = $clog2(NUM_SLOTS)
) (
   input  logic [NUM_SLOTS-1:0] occ_i,
   output logic [TOKEN_W-1:0]   idx_o,
   output logic                 any_free_o
);

   always_comb begin
      idx_o      = '0;
      any_free_o = 1'b0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (!occ_i[i] && !any_free_o) begin
            idx_o      = TOKEN_W'(i);
            any_free_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/park_slot_manager.sv
// Registered parking-bay occupancy manager: entry allocation, exit release, preload/recount.
// Optional pulse statistics counters enabled by defining PARK_STATS_EN.
module park_slot_manager
   import park_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 8,
   parameter int unsigned TOKEN_W   = $clog2(NUM_SLOTS),
   parameter int unsigned CNT_W     = $clog2(NUM_SLOTS + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_load,
   input  logic [NUM_SLOTS-1:0] cfg_pattern,
   input  logic                 entry_req,
   input  logic                 exit_req,
   input  logic [TOKEN_W-1:0]   exit_token,
   output logic                 entry_ack,
   output logic                 entry_rej,
   output logic [TOKEN_W-1:0]   entry_token,
   output logic                 exit_ack,
   output logic                 exit_err,
   output logic [NUM_SLOTS-1:0] park_location,
   output logic [CNT_W-1:0]     free_count,
   output logic                 full,
   output logic                 busy
`ifdef PARK_STATS_EN
   ,
   output logic [STAT_W-1:0]    stat_entries,
   output logic [STAT_W-1:0]    stat_rejects,
   output logic [STAT_W-1:0]    stat_errors
`endif
);

   park_state_e            state_q, state_d;
   logic [NUM_SLOTS-1:0]   park_q, park_d;
   logic [CNT_W-1:0]       free_q, free_d;
   logic                   full_q, full_d;
   logic                   busy_q, busy_d;
   logic                   eack_q, eack_d;
   logic                   erej_q, erej_d;
   logic                   xack_q, xack_d;
   logic                   xerr_q, xerr_d;
   logic [TOKEN_W-1:0]     etok_q, etok_d;

   logic [TOKEN_W-1:0]     free_idx;
   logic                   any_free;
   logic                   exit_ok;
   logic [POP_MAX_W-1:0]   padded;

   park_free_finder #(
      .NUM_SLOTS (NUM_SLOTS),
      .TOKEN_W   (TOKEN_W)
   ) u_finder (
      .occ_i      (park_q),
      .idx_o      (free_idx),
      .any_free_o (any_free)
   );

   always_comb begin
      padded                 = '0;
      padded[NUM_SLOTS-1:0]  = park_q;
      exit_ok                = (32'(exit_token) < NUM_SLOTS) && park_q[exit_token];
   end

   always_comb begin
      state_d = state_q;
      park_d  = park_q;
      free_d  = free_q;
      full_d  = full_q;
      busy_d  = 1'b0;
      eack_d  = 1'b0;
      erej_d  = 1'b0;
      xack_d  = 1'b0;
      xerr_d  = 1'b0;
      etok_d  = etok_q;
      case (state_q)
         S_RUN: begin
            if (cfg_load) begin
               park_d  = cfg_pattern;
               busy_d  = 1'b1;
               state_d = S_RECOUNT;
            end else begin
               // Allocation uses the pre-exit vector, so a bay vacated this cycle is never re-granted.
               if (entry_req) begin
                  if (any_free) begin
                     park_d[free_idx] = 1'b1;
                     eack_d           = 1'b1;
                     etok_d           = free_idx;
                  end else begin
                     erej_d = 1'b1;
                  end
               end
               if (exit_req) begin
                  if (exit_ok) begin
                     park_d[exit_token] = 1'b0;
                     xack_d             = 1'b1;
                  end else begin
                     xerr_d = 1'b1;
                  end
               end
               free_d = free_q + CNT_W'(xack_d) - CNT_W'(eack_d);
               full_d = (free_d == '0);
            end
         end
         S_RECOUNT: begin
            if (cfg_load) begin
               park_d = cfg_pattern;
               busy_d = 1'b1;
            end else begin
               free_d  = CNT_W'(NUM_SLOTS - popcount(padded));
               full_d  = (free_d == '0);
               state_d = S_RUN;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_RUN;
         park_q  <= '0;
         free_q  <= CNT_W'(NUM_SLOTS);
         full_q  <= 1'b0;
         busy_q  <= 1'b0;
         eack_q  <= 1'b0;
         erej_q  <= 1'b0;
         xack_q  <= 1'b0;
         xerr_q  <= 1'b0;
         etok_q  <= '0;
      end else begin
         state_q <= state_d;
         park_q  <= park_d;
         free_q  <= free_d;
         full_q  <= full_d;
         busy_q  <= busy_d;
         eack_q  <= eack_d;
         erej_q  <= erej_d;
         xack_q  <= xack_d;
         xerr_q  <= xerr_d;
         etok_q  <= etok_d;
      end
   end

   assign entry_ack     = eack_q;
   assign entry_rej     = erej_q;
   assign entry_token   = etok_q;
   assign exit_ack      = xack_q;
   assign exit_err      = xerr_q;
   assign park_location = park_q;
   assign free_count    = free_q;
   assign full          = full_q;
   assign busy          = busy_q;

`ifdef PARK_STATS_EN
   logic [STAT_W-1:0] sent_q, srej_q, serr_q;

   // Counters advance on the same edge the corresponding pulse is registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sent_q <= '0;
         srej_q <= '0;
         serr_q <= '0;
      end else begin
         if (eack_d && sent_q != '1) sent_q <= sent_q + 1'b1;
         if (erej_d && srej_q != '1) srej_q <= srej_q + 1'b1;
         if (xerr_d && serr_q != '1) serr_q <= serr_q + 1'b1;
      end
   end

   assign stat_entries = sent_q;
   assign stat_rejects = srej_q;
   assign stat_errors  = serr_q;
`endif

endmodule

// File: tb/tb_park_slot_manager.sv
// Directed table-driven bench for park_slot_manager (8-bay instance plus a 6-bay range check).
module tb_park_slot_manager;
   import park_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_load, entry_req, exit_req;
   logic [7:0] cfg_pattern;
   logic [2:0] exit_token;
   logic       entry_ack, entry_rej, exit_ack, exit_err, full, busy;
   logic [2:0] entry_token;
   logic [7:0] park_location;
   logic [3:0] free_count;

   logic       c6_load, e6_req, x6_req;
   logic [5:0] c6_pat;
   logic [2:0] x6_tok;
   logic       e6_ack, e6_rej, x6_ack, x6_err, full6, busy6;
   logic [2:0] e6_tok;
   logic [5:0] loc6;
   logic [2:0] free6;

`ifdef PARK_STATS_EN
   logic [15:0] st_ent, st_rej, st_err;
   logic [15:0] s6_ent, s6_rej, s6_err;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   park_slot_manager #(.NUM_SLOTS(8)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .entry_req(entry_req), .exit_req(exit_req), .exit_token(exit_token),
      .entry_ack(entry_ack), .entry_rej(entry_rej), .entry_token(entry_token),
      .exit_ack(exit_ack), .exit_err(exit_err), .park_location(park_location),
      .free_count(free_count), .full(full), .busy(busy)
`ifdef PARK_STATS_EN
      , .stat_entries(st_ent), .stat_rejects(st_rej), .stat_errors(st_err)
`endif
   );

   park_slot_manager #(.NUM_SLOTS(6)) dut6 (
      .clk(clk), .rst_n(rst_n), .cfg_load(c6_load), .cfg_pattern(c6_pat),
      .entry_req(e6_req), .exit_req(x6_req), .exit_token(x6_tok),
      .entry_ack(e6_ack), .entry_rej(e6_rej), .entry_token(e6_tok),
      .exit_ack(x6_ack), .exit_err(x6_err), .park_location(loc6),
      .free_count(free6), .full(full6), .busy(busy6)
`ifdef PARK_STATS_EN
      , .stat_entries(s6_ent), .stat_rejects(s6_rej), .stat_errors(s6_err)
`endif
   );

   typedef struct {
      logic       cfg;
      logic [7:0] pat;
      logic       ent;
      logic       ext;
      logic [2:0] tok;
      logic       e_ack;
      logic       e_rej;
      logic [2:0] e_tok;
      logic       x_ack;
      logic       x_err;
      logic [7:0] loc;
      logic [3:0] free;
      logic       full;
      logic       busy;
      logic       chk_cnt;
   } vec_t;

   vec_t vecs[24];

   function automatic vec_t V(
      input logic cfg, input logic [7:0] pat, input logic ent, input logic ext, input logic [2:0] tok,
      input logic ea, input logic er, input logic [2:0] et, input logic xa, input logic xe,
      input logic [7:0] loc, input logic [3:0] fr, input logic fl, input logic bz, input logic cc);
      vec_t v;
      v.cfg = cfg; v.pat = pat; v.ent = ent; v.ext = ext; v.tok = tok;
      v.e_ack = ea; v.e_rej = er; v.e_tok = et; v.x_ack = xa; v.x_err = xe;
      v.loc = loc; v.free = fr; v.full = fl; v.busy = bz; v.chk_cnt = cc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cfg_load = 1'b0; entry_req = 1'b0; exit_req = 1'b0;
      e6_req = 1'b0; x6_req = 1'b0; c6_load = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".loc"},  32'(park_location), 32'h00);
      chk({tag, ".free"}, 32'(free_count), 32'd8);
      chk({tag, ".full"}, 32'(full), 32'd0);
      chk({tag, ".busy"}, 32'(busy), 32'd0);
      chk({tag, ".pulses"}, 32'({entry_ack, entry_rej, exit_ack, exit_err}), 32'd0);
      chk({tag, ".etok"}, 32'(entry_token), 32'd0);
   endtask

   initial begin
      //            cfg pat   ent ext tok  ack rej etk xak xer loc   free full busy chk
      vecs[0]  = V(0, 8'h00, 1, 0, 3'd0, 1, 0, 3'd0, 0, 0, 8'h01, 4'd7, 0, 0, 1);
      vecs[1]  = V(0, 8'h00, 1, 0, 3'd0, 1, 0, 3'd1, 0, 0, 8'h03, 4'd6, 0, 0, 1);
      vecs[2]  = V(0, 8'h00, 1, 0, 3'd0, 1, 0, 3'd2, 0, 0, 8'h07, 4'd5, 0, 0, 1);
      vecs[3]  = V(0, 8'h00, 1, 0, 3'd0, 1, 0, 3'd3, 0, 0, 8'h0F, 4'd4, 0, 0, 1);
      vecs[4]  = V(0, 8'h00, 1, 0, 3'd0, 1, 0, 3'd4, 0, 0, 8'h1F, 4'd3, 0, 0, 1);
      vecs[5]  = V(0, 8'h00, 1, 0, 3'd0, 1, 0, 3'd5, 0, 0, 8'h3F, 4'd2, 0, 0, 1);
      vecs[6]  = V(0, 8'h00, 1, 0, 3'd0, 1, 0, 3'd6, 0, 0, 8'h7F, 4'd1, 0, 0, 1);
      vecs[7]  = V(0, 8'h00, 1, 0, 3'd0, 1, 0, 3'd7, 0, 0, 8'hFF, 4'd0, 1, 0, 1);
      vecs[8]  = V(0, 8'h00, 1, 0, 3'd0, 0, 1, 3'd7, 0, 0, 8'hFF, 4'd0, 1, 0, 1);
      vecs[9]  = V(0, 8'h00, 0, 1, 3'd3, 0, 0, 3'd7, 1, 0, 8'hF7, 4'd1, 0, 0, 1);
      vecs[10] = V(0, 8'h00, 1, 0, 3'd0, 1, 0, 3'd3, 0, 0, 8'hFF, 4'd0, 1, 0, 1);
      vecs[11] = V(0, 8'h00, 1, 1, 3'd2, 0, 1, 3'd3, 1, 0, 8'hFB, 4'd1, 0, 0, 1);
      vecs[12] = V(0, 8'h00, 0, 1, 3'd2, 0, 0, 3'd3, 0, 1, 8'hFB, 4'd1, 0, 0, 1);
      vecs[13] = V(0, 8'h00, 0, 1, 3'd5, 0, 0, 3'd3, 1, 0, 8'hDB, 4'd2, 0, 0, 1);
      vecs[14] = V(0, 8'h00, 0, 1, 3'd5, 0, 0, 3'd3, 0, 1, 8'hDB, 4'd2, 0, 0, 1);
      vecs[15] = V(0, 8'h00, 1, 1, 3'd0, 1, 0, 3'd2, 1, 0, 8'hDE, 4'd2, 0, 0, 1);
      vecs[16] = V(1, 8'h05, 1, 1, 3'd1, 0, 0, 3'd2, 0, 0, 8'h05, 4'd2, 0, 1, 1);
      vecs[17] = V(0, 8'h00, 1, 0, 3'd0, 0, 0, 3'd2, 0, 0, 8'h05, 4'd6, 0, 0, 1);
      vecs[18] = V(0, 8'h00, 1, 0, 3'd0, 1, 0, 3'd1, 0, 0, 8'h07, 4'd5, 0, 0, 1);
      vecs[19] = V(1, 8'hFF, 0, 0, 3'd0, 0, 0, 3'd1, 0, 0, 8'hFF, 4'd5, 0, 1, 1);
      vecs[20] = V(1, 8'h00, 1, 0, 3'd0, 0, 0, 3'd1, 0, 0, 8'h00, 4'd0, 0, 1, 0);
      vecs[21] = V(0, 8'h00, 0, 0, 3'd0, 0, 0, 3'd1, 0, 0, 8'h00, 4'd8, 0, 0, 1);
      vecs[22] = V(0, 8'h00, 0, 1, 3'd7, 0, 0, 3'd1, 0, 1, 8'h00, 4'd8, 0, 0, 1);
      vecs[23] = V(0, 8'h00, 1, 1, 3'd0, 1, 0, 3'd0, 0, 1, 8'h01, 4'd7, 0, 0, 1);

      rst_n = 1'b0;
      cfg_load = 1'b0; cfg_pattern = '0; entry_req = 1'b0; exit_req = 1'b0; exit_token = '0;
      c6_load = 1'b0; c6_pat = '0; e6_req = 1'b0; x6_req = 1'b0; x6_tok = '0;
      step();
      step();
      chk_reset_vals("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 24; i++) begin
         cfg_load = vecs[i].cfg; cfg_pattern = vecs[i].pat;
         entry_req = vecs[i].ent; exit_req = vecs[i].ext; exit_token = vecs[i].tok;
         step();
         chk($sformatf("v%0d.eack", i), 32'(entry_ack), 32'(vecs[i].e_ack));
         chk($sformatf("v%0d.erej", i), 32'(entry_rej), 32'(vecs[i].e_rej));
         chk($sformatf("v%0d.etok", i), 32'(entry_token), 32'(vecs[i].e_tok));
         chk($sformatf("v%0d.xack", i), 32'(exit_ack), 32'(vecs[i].x_ack));
         chk($sformatf("v%0d.xerr", i), 32'(exit_err), 32'(vecs[i].x_err));
         chk($sformatf("v%0d.loc", i), 32'(park_location), 32'(vecs[i].loc));
         chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
         if (vecs[i].chk_cnt) begin
            chk($sformatf("v%0d.free", i), 32'(free_count), 32'(vecs[i].free));
            chk($sformatf("v%0d.full", i), 32'(full), 32'(vecs[i].full));
         end
      end

`ifdef PARK_STATS_EN
      chk("stat.entries", 32'(st_ent), 32'd12);
      chk("stat.rejects", 32'(st_rej), 32'd2);
      chk("stat.errors",  32'(st_err), 32'd4);
`endif

      // Reset asserted while a load and a request are also present: reset wins.
      cfg_load = 1'b1; cfg_pattern = 8'hAA; entry_req = 1'b1; exit_req = 1'b1; exit_token = 3'd0;
      rst_n = 1'b0;
      step();
      chk_reset_vals("midrst");
`ifdef PARK_STATS_EN
      chk("midrst.stat_ent", 32'(st_ent), 32'd0);
      chk("midrst.stat_rej", 32'(st_rej), 32'd0);
      chk("midrst.stat_err", 32'(st_err), 32'd0);
`endif
      rst_n = 1'b1;
      step();
      chk_reset_vals("postrst");

      // 6-bay instance: out-of-range tokens, fill to full, reject.
      x6_req = 1'b1; x6_tok = 3'd7;
      step();
      chk("n6.tok7.err", 32'(x6_err), 32'd1);
      chk("n6.tok7.free", 32'(free6), 32'd6);
      x6_req = 1'b1; x6_tok = 3'd6;
      step();
      chk("n6.tok6.err", 32'(x6_err), 32'd1);
      for (int i = 0; i < 6; i++) begin
         e6_req = 1'b1;
         step();
         chk($sformatf("n6.fill%0d.tok", i), 32'({e6_ack, e6_tok}), 32'({1'b1, 3'(i)}));
      end
      chk("n6.full", 32'({full6, free6, loc6}), 32'({1'b1, 3'd0, 6'h3F}));
      e6_req = 1'b1;
      step();
      chk("n6.rej", 32'({e6_rej, e6_ack}), 32'b10);

`ifdef PARK_STATS_EN
      for (int i = 0; i < 8; i++) begin
         entry_req = 1'b1;
         step();
      end
      for (int i = 0; i < 65540; i++) begin
         entry_req = 1'b1;
         step();
      end
      chk("stat.sat_rej", 32'(st_rej), 32'hFFFF);
      chk("stat.sat_ent", 32'(st_ent), 32'd8);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
